dividend_reconstructor: RTL and testbench
=========================================

DIVIDEND_RECONSTRUCTOR -- requirements
Module: dividend_reconstructor

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed: quotient, divisor and remainder 5 bits, dividend 10 bits.
REQ-002 The block SHALL have a port CLK, input, width 1: single clock; all state changes on its rising edge.
REQ-003 The block SHALL have a port RST, input, width 1: synchronous reset, active-low, sampled on the CLK rising edge.
REQ-004 The block SHALL have a port Start, input, width 1: request to reconstruct; sampled only in IDLE and DONE.
REQ-005 The block SHALL have a port Quo, input, width 5: unsigned quotient operand.
REQ-006 The block SHALL have a port Divisor, input, width 5: unsigned divisor operand.
REQ-007 The block SHALL have a port Rem, input, width 5: unsigned remainder operand.
REQ-008 The block SHALL have a port Dividend, output, width 10: registered result Quo*Divisor+Rem.
REQ-009 The block SHALL have a port FINISH, output, width 1: one-cycle done pulse.
REQ-010 The block SHALL have a port DIVBYZERO, output, width 1: Divisor was 0 for the completed operation.
REQ-011 The block SHALL have a port INVALID, output, width 1: Divisor nonzero and Rem >= Divisor for the completed operation.

Function
REQ-012 The block SHALL implement states IDLE, LOAD, MUL and DONE, with internal registers: multiplicand (10 b), multiplier (5 b), accumulator (10 b) and a 3-bit iteration counter.
REQ-013 In IDLE with Start=1 at a rising edge (E0), the block SHALL go to LOAD; with Start=0 it SHALL stay in IDLE.
REQ-014 At E1, LOAD SHALL do all of the following:
- register Quo as multiplier, and Divisor zero-extended as multiplicand;
- set accumulator to Rem zero-extended and counter to 0;
- latch the DIVBYZERO/INVALID conditions into internal flags;
- go to MUL.
REQ-015 Operands SHALL be sampled only at E1; input changes after E1 SHALL NOT affect the result.
REQ-016 Each MUL edge SHALL perform one shift-add step:
- if the multiplier LSB is 1, add the multiplicand to the accumulator;
- shift the multiplicand left 1 and the multiplier right 1;
- increment the counter.
REQ-017 MUL SHALL run exactly 5 edges (E2..E6); on the edge where the counter equals 4, the block SHALL go to DONE.
REQ-018 At E6, the block SHALL load Dividend with the final accumulator and DIVBYZERO/INVALID with the latched flags.
REQ-019 FINISH SHALL be 1 only while in DONE (the cycle between E6 and E7), giving fixed latency: FINISH high 6 edges after the edge that sampled Start.
REQ-020 From DONE, the block SHALL go to LOAD if Start=1, else to IDLE, so back-to-back operations are allowed.
REQ-021 Start SHALL be ignored in LOAD and MUL; no queuing and no abort.
REQ-022 Arithmetic SHALL be unsigned. The maximum result is 31*31+31 = 992, which fits in 10 bits, so no overflow output exists.
REQ-023 Divisor=0 SHALL take the normal 5-cycle path, yielding Dividend=Rem and DIVBYZERO=1, with INVALID=0.
REQ-024 Dividend, DIVBYZERO and INVALID SHALL hold their values from E6 until the E6 of the next operation.

Reset
REQ-025 While RST=0 at a rising edge, the block SHALL go to IDLE and clear Dividend, FINISH, DIVBYZERO, INVALID, the counter and all internal registers to 0.
REQ-026 Reset SHALL override Start and any in-progress operation, including mid-MUL.
REQ-027 After RST returns to 1, the block SHALL require a new Start, with no partial result retained.

Verification
REQ-028 The bench SHALL cover: Quo=13, Divisor=7, Rem=5, Start pulsed one cycle -> FINISH one cycle, 6 edges after Start sampled; Dividend=96 (0x060); DIVBYZERO=0, INVALID=0.
REQ-029 The bench SHALL cover: Quo=31, Divisor=31, Rem=30 -> Dividend=991; flags 0. Also Quo=0, Divisor=5, Rem=4 -> Dividend=4.
REQ-030 The bench SHALL cover: Quo=5, Divisor=0, Rem=3 -> Dividend=3, DIVBYZERO=1, INVALID=0, same latency as a normal operation.
REQ-031 The bench SHALL cover: Quo=2, Divisor=7, Rem=9 -> Dividend=23, INVALID=1, DIVBYZERO=0.
REQ-032 The bench SHALL cover Start held high continuously with operand changes after E1:
- the first result is unaffected by the changes;
- a second operation begins straight from DONE;
- FINISH pulses every 7 cycles.
REQ-033 The bench SHALL cover RST=0 asserted during the third MUL edge -> next cycle in IDLE, all outputs 0, and no FINISH until a new Start.

Source files
------------

// File: rtl/dividend_reconstructor.sv
// -----------------------------------------------------------------------------
// dividend_reconstructor
//
// Purpose:
//   Rebuilds a dividend from its division results:
//     Dividend = Quo * Divisor + Rem
//   The product is formed with a 5-step shift-add multiplier. The accumulator
//   is seeded with Rem, so the sum is built in the same loop.
//   Timeline:
//     - Start is sampled in IDLE (E0).
//     - Operands are captured in LOAD (E1).
//     - MUL steps run on E2..E6.
//     - The result is registered at E6.
//     - FINISH is high for the single DONE cycle.
//
// Ports:
//   CLK        in   1  clock, rising edge
//   RST        in   1  synchronous reset, active-low
//   Start      in   1  begin an operation (honoured in IDLE and DONE only)
//   Quo        in   5  unsigned quotient
//   Divisor    in   5  unsigned divisor
//   Rem        in   5  unsigned remainder
//   Dividend   out 10  registered Quo*Divisor+Rem of the last operation
//   FINISH     out  1  high for the one cycle spent in DONE
//   DIVBYZERO  out  1  last operation had Divisor == 0
//   INVALID    out  1  last operation had Divisor != 0 and Rem >= Divisor
// -----------------------------------------------------------------------------
module dividend_reconstructor (
  input  logic       CLK,
  input  logic       RST,
  input  logic       Start,
  input  logic [4:0] Quo,
  input  logic [4:0] Divisor,
  input  logic [4:0] Rem,
  output logic [9:0] Dividend,
  output logic       FINISH,
  output logic       DIVBYZERO,
  output logic       INVALID
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    MUL  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [2:0] LAST_STEP = 3'd4;

  state_t     state_q,    state_d;
  logic [9:0] mcand_q,    mcand_d;
  logic [4:0] mplier_q,   mplier_d;
  logic [9:0] acc_q,      acc_d;
  logic [2:0] cnt_q,      cnt_d;
  logic       dbz_q,      dbz_d;
  logic       inv_q,      inv_d;
  logic [9:0] dividend_q, dividend_d;
  logic       dbz_out_q,  dbz_out_d;
  logic       inv_out_q,  inv_out_d;

  logic [9:0] acc_step;

  // One shift-add partial product.
  // The maximum result is 992, so the sum never exceeds 10 bits.
  function automatic logic [9:0] shift_add_step(input logic [9:0] acc,
                                                input logic [9:0] mcand,
                                                input logic       take);
    shift_add_step = take ? (acc + mcand) : acc;
  endfunction

  assign acc_step = shift_add_step(acc_q, mcand_q, mplier_q[0]);

  always_comb begin
    state_d    = state_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    dbz_d      = dbz_q;
    inv_d      = inv_q;
    dividend_d = dividend_q;
    dbz_out_d  = dbz_out_q;
    inv_out_d  = inv_out_q;

    case (state_q)
      IDLE: begin
        if (Start) state_d = LOAD;
      end
      LOAD: begin
        mplier_d = Quo;
        mcand_d  = {5'b0, Divisor};
        acc_d    = {5'b0, Rem};
        cnt_d    = 3'd0;
        dbz_d    = (Divisor == 5'd0);
        inv_d    = (Divisor != 5'd0) && (Rem >= Divisor);
        state_d  = MUL;
      end
      MUL: begin
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 3'd1;
        if (cnt_q == LAST_STEP) begin
          // The last step's add must reach the output on this edge,
          // so take the combinational sum rather than acc_q.
          dividend_d = acc_step;
          dbz_out_d  = dbz_q;
          inv_out_d  = inv_q;
          state_d    = DONE;
        end
      end
      DONE: begin
        state_d = Start ? LOAD : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q    <= IDLE;
      mcand_q    <= '0;
      mplier_q   <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      dbz_q      <= 1'b0;
      inv_q      <= 1'b0;
      dividend_q <= '0;
      dbz_out_q  <= 1'b0;
      inv_out_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      dbz_q      <= dbz_d;
      inv_q      <= inv_d;
      dividend_q <= dividend_d;
      dbz_out_q  <= dbz_out_d;
      inv_out_q  <= inv_out_d;
    end
  end

  assign Dividend  = dividend_q;
  assign FINISH    = (state_q == DONE);
  assign DIVBYZERO = dbz_out_q;
  assign INVALID   = inv_out_q;

endmodule

// File: tb/tb_dividend_reconstructor.sv
module tb_dividend_reconstructor;

  logic       CLK = 1'b0;
  logic       RST;
  logic       Start;
  logic [4:0] Quo;
  logic [4:0] Divisor;
  logic [4:0] Rem;
  logic [9:0] Dividend;
  logic       FINISH;
  logic       DIVBYZERO;
  logic       INVALID;

  int checks   = 0;
  int failures = 0;

  dividend_reconstructor dut (
    .CLK       (CLK),
    .RST       (RST),
    .Start     (Start),
    .Quo       (Quo),
    .Divisor   (Divisor),
    .Rem       (Rem),
    .Dividend  (Dividend),
    .FINISH    (FINISH),
    .DIVBYZERO (DIVBYZERO),
    .INVALID   (INVALID)
  );

  always #5 CLK = ~CLK;

  // Advance one rising edge; outputs are then sampled 1 time unit later.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [9:0] obs,
                     input logic [9:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One isolated operation.
  // Start is held for exactly one edge (E0), and the latency is checked
  // edge by edge through the sequence.
  task automatic run_op(input string tag,
                        input logic [4:0] q,
                        input logic [4:0] d,
                        input logic [4:0] r,
                        input logic [9:0] exp_div,
                        input logic       exp_dbz,
                        input logic       exp_inv);
    Quo     = q;
    Divisor = d;
    Rem     = r;
    Start   = 1'b1;
    tick();                                   // E0
    Start = 1'b0;
    chk({tag, "_fin_e0"}, {9'b0, FINISH}, 10'd0);
    for (int e = 1; e <= 5; e++) begin        // E1..E5
      tick();
      chk($sformatf("%s_fin_e%0d", tag, e), {9'b0, FINISH}, 10'd0);
    end
    tick();                                   // E6
    chk({tag, "_fin_e6"}, {9'b0, FINISH},    10'd1);
    chk({tag, "_div"},    Dividend,          exp_div);
    chk({tag, "_dbz"},    {9'b0, DIVBYZERO}, {9'b0, exp_dbz});
    chk({tag, "_inv"},    {9'b0, INVALID},   {9'b0, exp_inv});
    tick();                                   // E7: back to IDLE
    chk({tag, "_fin_e7"},  {9'b0, FINISH}, 10'd0);
    chk({tag, "_div_hold"}, Dividend,      exp_div);
  endtask

  initial begin
    RST     = 1'b0;
    Start   = 1'b1;
    Quo     = 5'd0;
    Divisor = 5'd0;
    Rem     = 5'd0;
    tick();
    tick();
    chk("rst_div", Dividend,          10'd0);
    chk("rst_fin", {9'b0, FINISH},    10'd0);
    chk("rst_dbz", {9'b0, DIVBYZERO}, 10'd0);
    chk("rst_inv", {9'b0, INVALID},   10'd0);
    Start = 1'b0;
    RST   = 1'b1;
    tick();
    chk("idle_fin", {9'b0, FINISH}, 10'd0);

    run_op("op13x7p5",  5'd13, 5'd7,  5'd5,  10'd96,  1'b0, 1'b0);
    run_op("op31x31p30", 5'd31, 5'd31, 5'd30, 10'd991, 1'b0, 1'b0);
    run_op("op0x5p4",   5'd0,  5'd5,  5'd4,  10'd4,   1'b0, 1'b0);
    run_op("divzero",   5'd5,  5'd0,  5'd3,  10'd3,   1'b1, 1'b0);
    chk("divzero_hold_dbz", {9'b0, DIVBYZERO}, 10'd1);

    // Start held high continuously, with operands changed after E1.
    // First op: 3*4+1 = 13.
    // Second op: operands captured at E8 from 10,10,2, giving 102.
    Quo     = 5'd3;
    Divisor = 5'd4;
    Rem     = 5'd1;
    Start   = 1'b1;
    tick();                                   // E0
    tick();                                   // E1: operands captured
    Quo     = 5'd10;
    Divisor = 5'd10;
    Rem     = 5'd2;
    for (int e = 2; e <= 5; e++) begin
      tick();
      chk($sformatf("b2b_fin_e%0d", e), {9'b0, FINISH}, 10'd0);
    end
    tick();                                   // E6
    chk("b2b_fin1", {9'b0, FINISH},    10'd1);
    chk("b2b_div1", Dividend,          10'd13);
    chk("b2b_dbz1", {9'b0, DIVBYZERO}, 10'd0);
    for (int e = 7; e <= 12; e++) begin       // DONE->LOAD->MUL...
      tick();
      chk($sformatf("b2b_fin_e%0d", e), {9'b0, FINISH}, 10'd0);
      chk($sformatf("b2b_hold_e%0d", e), Dividend, 10'd13);
    end
    tick();                                   // E13 = E6 + 7
    chk("b2b_fin2", {9'b0, FINISH}, 10'd1);
    chk("b2b_div2", Dividend,       10'd102);
    Start = 1'b0;
    tick();
    chk("b2b_fin_end", {9'b0, FINISH}, 10'd0);

    run_op("invalid", 5'd2, 5'd7, 5'd9, 10'd23, 1'b0, 1'b1);

    // Reset sampled on the third MUL edge of an operation.
    Quo     = 5'd13;
    Divisor = 5'd7;
    Rem     = 5'd5;
    Start   = 1'b1;
    tick();                                   // E0
    Start = 1'b0;
    tick();                                   // E1
    tick();                                   // E2: first MUL step
    tick();                                   // E3: second MUL step
    RST = 1'b0;
    tick();                                   // E4: reset wins
    RST = 1'b1;
    chk("mrst_div", Dividend,          10'd0);
    chk("mrst_fin", {9'b0, FINISH},    10'd0);
    chk("mrst_dbz", {9'b0, DIVBYZERO}, 10'd0);
    chk("mrst_inv", {9'b0, INVALID},   10'd0);
    for (int e = 0; e < 8; e++) begin
      tick();
      chk($sformatf("mrst_nofin_%0d", e), {9'b0, FINISH}, 10'd0);
      chk($sformatf("mrst_div_%0d", e),   Dividend,       10'd0);
    end

    // A fresh Start after reset completes normally.
    run_op("post_rst", 5'd13, 5'd7, 5'd5, 10'd96, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog in case the clocked sequence is ever stalled.
  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

endmodule
